serial_sub64: RTL and testbench
===============================

// Module: serial_sub64
// PURPOSE
//  Bit-serial two's-complement subtractor: the inverse operation of the 1-bit full-adder datapath.
//  Computes A - B as A + ~B + 1 and ripples STEP bits per clock through a single adder slice.
//  Outputs Y86-style condition codes (ZF, SF, OF) plus borrow.
//  Serves as the area-minimal ALU subtract engine for the sequential Y86-64 core.
// PARAMETERS
//  WIDTH  64  operand/result width in bits
//  STEP   1   bits processed per cycle; must divide WIDTH; N = WIDTH/STEP cycles per operation
// PORTS
//  clk     in   1      single clock, all state updates on rising edge
//  rst     in   1      synchronous, active-high reset
//  start   in   1      request: latch a/b and begin (accepted only when ready=1)
//  a       in   WIDTH  minuend (signed)
//  b       in   WIDTH  subtrahend (signed)
//  op      in   1      only with SERIAL_SUB_ADD_EN: 0 = subtract, 1 = add
//  ready   out  1      1 in IDLE or DONE: start will be accepted this cycle
//  busy    out  1      1 while in RUN
//  done    out  1      one-cycle pulse: result and flags valid
//  result  out  WIDTH  A-B (or A+B), held until the next accepted start or reset
//  cf      out  1      borrow for subtract (1 when unsigned a < unsigned b); carry-out for add
//  zf      out  1      result == 0
//  sf      out  1      result[WIDTH-1]
//  of      out  1      signed overflow
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE; ready=1; busy=0; done=0; result, cf, zf, sf and of = 0; counter=0.
//  - Reset has priority over everything. Reset during RUN abandons the operation; no done pulse is produced.
//  - States: IDLE -> RUN on start; RUN -> RUN while count<N-1; RUN -> DONE on the last slice;
//    DONE -> RUN if start, else IDLE.
//  - Accept edge: latch a into shift reg A and b into shift reg B (inverted for subtract).
//    Carry reg = 1 for subtract, 0 for add. count=0. Save a[W-1] and the effective b sign for OF.
//  - Each RUN edge: slice sums the low STEP bits of A and B with carry. Sum bits shift into result from the MSB side.
//    A and B shift right by STEP. Carry reg <- slice carry-out. count++.
//  - Latency: start accepted at edge k -> done=1 after edge k+N (64 cycles at defaults).
//    Back-to-back: start during DONE is accepted, and the next done follows N cycles later.
//  - start is ignored when busy=1 (no queueing). Operands need only be stable in the accept cycle.
//  - result is updated in place during RUN (not valid until done). All flags update only at the DONE edge.
//  - Flags: zf = ~|result; sf = result[W-1]; of = (a_sign == beff_sign) & (result[W-1] != a_sign).
//    beff_sign = ~b[W-1] for subtract and b[W-1] for add. cf = ~carry_out for subtract and carry_out for add.
//  - Wrap-around: result is modulo 2^WIDTH; no saturation.
// CONFIGURATION
//  SERIAL_SUB_ADD_EN defined: op port exists; op is latched at accept and selects add or subtract as above.
//  Not defined: no op port; the block always subtracts; add logic is absent.
// STRUCTURE
//  Shared package serial_alu_pkg: state encoding (S_IDLE, S_RUN, S_DONE) and OP_SUB=0, OP_ADD=1 constants.
//  Width-check helper in the package: ensures WIDTH % STEP == 0 and supplies the counter width clog2(N).
//  One sub-module, serial_fa_slice: combinational STEP-bit ripple of 1-bit full adders (a, b, cin -> sum, cout).
//  Top level holds the FSM, the shift registers, the counter and the flag logic.
// TESTING
//  1. rst, then start with a=5, b=3 -> done exactly 64 cycles later; result=2, cf=0, zf=0, sf=0, of=0.
//  2. a=3, b=5 -> result=64'hFFFF_FFFF_FFFF_FFFE; cf=1, sf=1, zf=0, of=0.
//  3. a=64'h8000_0000_0000_0000, b=1 -> result=64'h7FFF_FFFF_FFFF_FFFF; of=1, sf=0, cf=0.
//  4. a=b=64'h1234 -> result=0, zf=1. Then start in the DONE cycle with a=0, b=1 -> result=all ones, sf=1, cf=1, 64 cycles later.
//  5. Pulse start at cycle 10 of RUN -> ignored. Assert rst at cycle 30 -> outputs as reset, no done pulse. Then 9-4 -> result=5.
//  6. With SERIAL_SUB_ADD_EN, op=1, a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> result=64'h8000_0000_0000_0000, of=1, sf=1, cf=0.
//     Also sweep STEP=4 and STEP=8 over cases 1-4 and confirm N = 16 and N = 8 cycles respectively.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU engines: FSM state encoding,
// operation codes and parameter helpers.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  // STEP must be non-zero and split WIDTH into whole slices.
  function automatic bit step_ok(input int unsigned width, input int unsigned step);
    return (step != 0) && ((width % step) == 0);
  endfunction

  // Slice counter width; at least one bit even for a single-slice operation.
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned step);
    int unsigned n;
    n = width / step;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_sub64_if.sv
// Request/result bundle for serial_sub64. The op signal exists only when
// SERIAL_SUB_ADD_EN is defined.
interface serial_sub64_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_ADD_EN
  logic             op;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cf;
  logic             zf;
  logic             sf;
  logic             of;

`ifdef SERIAL_SUB_ADD_EN
  modport master (output start, a, b, op, input ready, busy, done, result, cf, zf, sf, of);
  modport slave  (input start, a, b, op, output ready, busy, done, result, cf, zf, sf, of);
`else
  modport master (output start, a, b, input ready, busy, done, result, cf, zf, sf, of);
  modport slave  (input start, a, b, output ready, busy, done, result, cf, zf, sf, of);
`endif
endinterface

// File: rtl/serial_fa_slice.sv
// Combinational STEP-bit ripple of 1-bit full adders.
module serial_fa_slice #(
  parameter int unsigned STEP = 1
) (
  input  logic [STEP-1:0] a_i,
  input  logic [STEP-1:0] b_i,
  input  logic            cin_i,
  output logic [STEP-1:0] sum_c_o,
  output logic            cout_c_o
);

  always_comb begin
    logic c;
    c       = cin_i;
    sum_c_o = '0;
    for (int i = 0; i < int'(STEP); i++) begin
      sum_c_o[i] = a_i[i] ^ b_i[i] ^ c;
      c          = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_c_o = c;
  end

endmodule

// File: rtl/serial_sub64.sv
// Bit-serial two's-complement subtractor (A + ~B + 1), STEP bits per clock,
// with Y86-style flags. Define SERIAL_SUB_ADD_EN to add an op input selecting add.
module serial_sub64
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned STEP  = 1
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub64_if.slave bus
);

  localparam int unsigned N  = WIDTH / STEP;
  localparam int unsigned CW = cnt_width(WIDTH, STEP);

  if (!step_ok(WIDTH, STEP)) begin : g_bad_step
    $error("serial_sub64: STEP must divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             carry_q, carry_d;
  logic             asign_q, asign_d, bsign_q, bsign_d;
  logic             cf_q, cf_d, zf_q, zf_d, sf_q, sf_d, of_q, of_d;
  logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic             in_sub_c, run_sub_c;
  logic [STEP-1:0]  sum_c;
  logic             cout_c;

`ifdef SERIAL_SUB_ADD_EN
  logic sub_q, sub_d;
  assign in_sub_c  = (bus.op == OP_SUB);
  assign run_sub_c = sub_q;
`else
  assign in_sub_c  = 1'b1;
  assign run_sub_c = 1'b1;
`endif

  serial_fa_slice #(.STEP(STEP)) u_slice (
    .a_i      (a_q[STEP-1:0]),
    .b_i      (b_q[STEP-1:0]),
    .cin_i    (carry_q),
    .sum_c_o  (sum_c),
    .cout_c_o (cout_c)
  );

  // Next-state, datapath and flag logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    asign_d = asign_q;
    bsign_d = bsign_q;
    cf_d    = cf_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    of_d    = of_q;
`ifdef SERIAL_SUB_ADD_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          a_d     = bus.a;
          b_d     = in_sub_c ? ~bus.b : bus.b;
          carry_d = in_sub_c;
          asign_d = bus.a[WIDTH-1];
          bsign_d = in_sub_c ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
`ifdef SERIAL_SUB_ADD_EN
          sub_d   = in_sub_c;
`endif
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        res_d   = (res_q >> STEP) | (WIDTH'(sum_c) << (WIDTH - STEP));
        a_d     = a_q >> STEP;
        b_d     = b_q >> STEP;
        carry_d = cout_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
          zf_d    = ~|res_d;
          sf_d    = res_d[WIDTH-1];
          of_d    = (asign_q == bsign_q) & (res_d[WIDTH-1] != asign_q);
          cf_d    = run_sub_c ? ~cout_c : cout_c;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d != S_RUN);
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      asign_q <= 1'b0;
      bsign_q <= 1'b0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_ADD_EN
      sub_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      asign_q <= asign_d;
      bsign_q <= bsign_d;
      cf_q    <= cf_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_ADD_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;
  assign bus.cf     = cf_q;
  assign bus.zf     = zf_q;
  assign bus.sf     = sf_q;
  assign bus.of     = of_q;

endmodule

// File: tb/tb_serial_sub64.sv
// Scoreboard bench for serial_sub64: directed cases plus random operands
// against an arithmetic reference model; STEP is a bench parameter.
module tb_serial_sub64;
  parameter int unsigned STEP = 1;
  localparam int unsigned W = 64;
  localparam int unsigned N = W / STEP;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_sub64_if #(.WIDTH(W)) bus ();

  serial_sub64 #(.WIDTH(W), .STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         cf, zf, sf, of;
    int unsigned  due;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: exact integer arithmetic, then compare against the wrapped result.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit add);
    exp_t e;
    logic signed [W+1:0] t;
    if (add) begin
      e.res = a + b;
      t     = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
      e.cf  = (e.res < a);
    end else begin
      e.res = a - b;
      t     = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
      e.cf  = (a < b);
    end
    e.zf  = (e.res == '0);
    e.sf  = e.res[W-1];
    e.of  = (t != $signed({{2{e.res[W-1]}}, e.res}));
    e.due = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result",  bus.result, e.res);
        chk("cf",      W'(bus.cf), W'(e.cf));
        chk("zf",      W'(bus.zf), W'(e.zf));
        chk("sf",      W'(bus.sf), W'(e.sf));
        chk("of",      W'(bus.of), W'(e.of));
        chk("latency", W'(cyc),    W'(e.due));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    chk("rst_ready",  W'(bus.ready), W'(1));
    chk("rst_busy",   W'(bus.busy),  W'(0));
    chk("rst_done",   W'(bus.done),  W'(0));
    chk("rst_result", bus.result,    '0);
    chk("rst_flags",  W'({bus.cf, bus.zf, bus.sf, bus.of}), W'(0));
    rst = 1'b0;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit add);
    exp_t e;
    for (int i = 0; i < int'(N) + 10 && bus.ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    if (bus.ready !== 1'b1) chk("ready_timeout", W'(bus.ready), W'(1));
    bus.a     = a;
    bus.b     = b;
`ifdef SERIAL_SUB_ADD_EN
    bus.op    = add;
`endif
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = {$urandom, $urandom};
    bus.b     = {$urandom, $urandom};
    e     = model(a, b, add);
    e.due = cyc + N;
    sb_q.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < int'(N) + 10 && bus.done !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    chk("done_seen", W'(bus.done), W'(1));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2 * int'(N) + 20 && sb_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", W'(sb_q.size()), W'(0));
      sb_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    bit           radd;
    logic [W-1:0] edge_v [6];
    edge_v = '{64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
               64'h7FFF_FFFF_FFFF_FFFF, 64'h1234};
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SERIAL_SUB_ADD_EN
    bus.op    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    issue(64'd5, 64'd3, 1'b0);                       wait_drain();
    issue(64'd3, 64'd5, 1'b0);                       wait_drain();
    issue(64'h8000_0000_0000_0000, 64'd1, 1'b0);     wait_drain();

    // Back-to-back: second start lands in the DONE cycle.
    issue(64'h1234, 64'h1234, 1'b0);
    wait_done();
    issue(64'd0, 64'd1, 1'b0);
    wait_drain();

    // Start during RUN must be ignored.
    issue(64'd100, 64'd7, 1'b0);
    repeat (N / 2) @(posedge clk);
    #1;
    bus.a = 64'd1; bus.b = 64'd1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_drain();
    repeat (N + 5) @(posedge clk);
    #1;

    // Reset mid-run abandons the operation with no done pulse.
    issue(64'd123, 64'd45, 1'b0);
    repeat ((N * 30) / 64) @(posedge clk);
    #1;
    do_reset();
    repeat (N + 5) @(posedge clk);
    #1;
    issue(64'd9, 64'd4, 1'b0);                       wait_drain();

`ifdef SERIAL_SUB_ADD_EN
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);     wait_drain();
`endif

    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : {$urandom, $urandom};
`ifdef SERIAL_SUB_ADD_EN
      radd = bit'($urandom_range(0, 1));
`else
      radd = 1'b0;
`endif
      if (sb_q.size() != 0 && $urandom_range(0, 2) == 0) begin
        wait_done();
      end else begin
        wait_drain();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      issue(ra, rb, radd);
    end
    wait_drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
